// File: rtl/main_bus_pkg.sv
// Shared definitions for the main data bus arbiter.
//   state_t : arbiter FSM states
//   SEL_*   : source codes understood by the 15-source main bus mux
//             (code 0 selects nothing and is treated as illegal)
package main_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] SEL_ALU = 4'd1;
    localparam logic [3:0] SEL_DR  = 4'd2;
    localparam logic [3:0] SEL_R1  = 4'd3;
    localparam logic [3:0] SEL_R10 = 4'd12;
    localparam logic [3:0] SEL_DM  = 4'd13;
    localparam logic [3:0] SEL_IM  = 4'd14;
    localparam logic [3:0] SEL_ID  = 4'd15;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker.
//   req     : request vector
//   ptr     : index that has highest priority this round
//   win     : one-hot winner (0 when no request)
//   win_idx : index of the winner
//   any     : at least one request present
module rr_arbiter #(
    parameter int N_REQ = 8,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] win,
    output logic [PTR_W-1:0] win_idx,
    output logic             any
);

    int idx;

    // Scan from ptr upward (wrapping); the first requester found wins.
    always_comb begin
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!any && req[idx]) begin
                any      = 1'b1;
                win[idx] = 1'b1;
                win_idx  = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/main_bus_arbiter.sv
// Round-robin arbiter for the 16-bit main data bus mux.
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   req       : per-requester bus request, held high while the bus is wanted
//   req_sel   : per-requester source code, slice i = [i*SEL_W +: SEL_W]
//   grant     : one-hot current owner (0 when idle)
//   bus_sel   : select code driven to the mux
//   bus_en    : mux enable, high only during XFER
//   data_vld  : one-hot, mux output valid for the owner (1 cycle after bus_en)
//   err_sel   : 1-cycle pulse in SETUP when the owner's code was 0
//
// Handshake: a requester raises req and keeps it high for as long as it
// wants the bus; grant is the acknowledgement. Every cycle with bus_en high
// is one beat, and that beat's data is marked by data_vld one cycle later.
// Dropping req while granted ends the tenure after the current beat.
module main_bus_arbiter
    import main_bus_pkg::*;
#(
    parameter int N_REQ     = 8,
    parameter int SEL_W     = 4,
    parameter int MAX_BEATS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*SEL_W-1:0] req_sel,
    output logic [N_REQ-1:0]       grant,
    output logic [SEL_W-1:0]       bus_sel,
    output logic                   bus_en,
    output logic [N_REQ-1:0]       data_vld,
    output logic                   err_sel
);

    localparam int         PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [3:0] BEAT_MAX = 4'(MAX_BEATS);

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner;
    logic [3:0]         beats;

    logic [N_REQ-1:0]   win;
    logic [PTR_W-1:0]   win_idx;
    logic               any;
    logic [SEL_W-1:0]   cand_sel;
    logic               owner_req;
    logic               others_req;
    logic               last_beat;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req     (req),
        .ptr     (ptr),
        .win     (win),
        .win_idx (win_idx),
        .any     (any)
    );

    assign cand_sel   = req_sel[int'(win_idx)*SEL_W +: SEL_W];
    assign owner_req  = req[owner];
    assign others_req = |(req & ~grant);
    assign last_beat  = (beats + 4'd1) == BEAT_MAX;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            beats    <= '0;
            grant    <= '0;
            bus_sel  <= '0;
            bus_en   <= 1'b0;
            data_vld <= '0;
            err_sel  <= 1'b0;
        end else begin
            // The mux registers its output on enable: valid one cycle later.
            data_vld <= bus_en ? grant : '0;
            err_sel  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any) begin
                        state <= SETUP;
                        grant <= win;
                        owner <= win_idx;
                        ptr   <= (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
                        // Code 0 selects nothing; fall back to the ALU source.
                        if (cand_sel == '0) begin
                            bus_sel <= SEL_W'(SEL_ALU);
                            err_sel <= 1'b1;
                        end else begin
                            bus_sel <= cand_sel;
                        end
                    end
                end
                SETUP: begin
                    state  <= XFER;
                    bus_en <= 1'b1;
                    beats  <= '0;
                end
                XFER: begin
                    if (!owner_req || (last_beat && others_req)) begin
                        state  <= RELEASE;
                        bus_en <= 1'b0;
                        grant  <= '0;
                        beats  <= '0;
                    end else if (last_beat) begin
                        // Nobody else waiting: restart the tenure window.
                        beats <= '0;
                    end else begin
                        beats <= beats + 4'd1;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_main_bus_arbiter.sv
// Self-checking bench for main_bus_arbiter: directed scenarios followed by
// randomized requests, all checked cycle by cycle against a tenure-level
// reference model, plus a grant-order scoreboard.
module tb_main_bus_arbiter;

    localparam int N_REQ     = 8;
    localparam int SEL_W     = 4;
    localparam int MAX_BEATS = 4;

    // ---------------- clock / reset ----------------
    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*SEL_W-1:0] req_sel;
    logic [N_REQ-1:0]       grant;
    logic [SEL_W-1:0]       bus_sel;
    logic                   bus_en;
    logic [N_REQ-1:0]       data_vld;
    logic                   err_sel;

    always #5 clk = ~clk;

    main_bus_arbiter #(
        .N_REQ     (N_REQ),
        .SEL_W     (SEL_W),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_sel  (req_sel),
        .grant    (grant),
        .bus_sel  (bus_sel),
        .bus_en   (bus_en),
        .data_vld (data_vld),
        .err_sel  (err_sel)
    );

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A tenure is: one arbitration cycle (IDLE), one SETUP cycle, a run of
    // beats, one turnaround cycle. m_phase names where we are in it.
    int               m_phase;      // 0 arbitrate, 1 setup, 2 beats, 3 turnaround
    int               m_ptr;
    int               m_owner;
    int               m_total;      // beats done in this tenure
    logic [N_REQ-1:0] e_grant;
    logic [SEL_W-1:0] e_sel;
    logic             e_en;
    logic [N_REQ-1:0] e_vld;
    logic             e_err;

    logic [3:0] exp_q[$];           // expected owner order
    int         own_log[$];         // observed owner order
    int         ten_len[$];         // observed bus_en run lengths
    int         run_len;
    logic [N_REQ-1:0] prev_grant;
    logic       prev_en;
    int         n_errsel;
    int         n_vld;
    int         sel_bad;

    task automatic model_reset();
        m_phase = 0; m_ptr = 0; m_owner = 0; m_total = 0;
        e_grant = '0; e_sel = '0; e_en = 1'b0; e_vld = '0; e_err = 1'b0;
        exp_q.delete();
        prev_grant = '0; prev_en = 1'b0; run_len = 0;
    endtask

    task automatic clear_logs();
        own_log.delete(); ten_len.delete();
        n_errsel = 0; n_vld = 0; sel_bad = 0;
    endtask

    // Outputs expected after the next rising edge, given inputs r/s there.
    task automatic model_next(input logic [N_REQ-1:0] r, input logic [N_REQ*SEL_W-1:0] s);
        logic [N_REQ-1:0] nv;
        logic [SEL_W-1:0] code;
        int w;
        nv    = e_en ? e_grant : '0;
        e_err = 1'b0;
        case (m_phase)
            0: if (r != '0) begin
                w = 0;
                for (int k = 0; k < N_REQ; k++) begin
                    w = (m_ptr + k) % N_REQ;
                    if (r[w]) break;
                end
                code    = s[w*SEL_W +: SEL_W];
                e_err   = (code == 0);
                e_sel   = (code == 0) ? SEL_W'(1) : code;
                e_grant = N_REQ'(1) << w;
                m_owner = w;
                m_ptr   = (w + 1) % N_REQ;
                m_phase = 1;
                exp_q.push_back(4'(w));
            end
            1: begin
                m_phase = 2;
                e_en    = 1'b1;
                m_total = 0;
            end
            2: begin
                m_total++;
                if (!r[m_owner] ||
                    ((m_total % MAX_BEATS) == 0 && (r & ~e_grant) != '0)) begin
                    m_phase = 3;
                    e_en    = 1'b0;
                    e_grant = '0;
                end
            end
            default: m_phase = 0;
        endcase
        e_vld = nv;
    endtask

    // ---------------- scoreboard ----------------
    task automatic compare_outputs();
        int idx;
        check_eq("grant", grant, e_grant);
        check_eq("bus_sel", bus_sel, e_sel);
        check_eq("bus_en", bus_en, e_en);
        check_eq("data_vld", data_vld, e_vld);
        check_eq("err_sel", err_sel, e_err);
        check_eq("grant_onehot0", $onehot0(grant), 1);
        check_eq("en_without_grant", bus_en && (grant == '0), 0);
        if (grant != '0 && prev_grant == '0) begin
            idx = 0;
            for (int i = 0; i < N_REQ; i++) if (grant[i]) idx = i;
            own_log.push_back(idx);
            check_eq("order_q_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check_eq("grant_order", idx, exp_q.pop_front());
        end
        if (bus_en) run_len++;
        else if (prev_en) begin
            ten_len.push_back(run_len);
            run_len = 0;
        end
        if (err_sel) n_errsel++;
        if (data_vld != '0) n_vld++;
        if (grant != '0 && bus_sel != 4'd7) sel_bad++;
        prev_grant = grant;
        prev_en    = bus_en;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic [N_REQ-1:0] r, input logic [N_REQ*SEL_W-1:0] s);
        req     = r;
        req_sel = s;
        model_next(r, s);
        @(posedge clk);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic hold(input logic [N_REQ-1:0] r, input logic [N_REQ*SEL_W-1:0] s, input int n);
        for (int i = 0; i < n; i++) step(r, s);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- stimulus ----------------
    logic [N_REQ-1:0]       rnd_req;
    logic [N_REQ*SEL_W-1:0] rnd_sel;

    initial begin
        rst = 1'b1; req = '0; req_sel = '0;
        model_reset();
        clear_logs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_grant", grant, 0);
        check_eq("rst_bus_sel", bus_sel, 0);
        check_eq("rst_bus_en", bus_en, 0);
        check_eq("rst_data_vld", data_vld, 0);
        check_eq("rst_err_sel", err_sel, 0);
        rst = 1'b0;

        // 1. single requester, 3 beats
        clear_logs();
        hold(8'h04, 32'(13) << 8, 4);
        hold(8'h00, 32'(13) << 8, 4);
        check_eq("s1_tenures", ten_len.size(), 1);
        if (ten_len.size() >= 1) check_eq("s1_beats", ten_len[0], 3);
        check_eq("s1_vld_pulses", n_vld, 3);

        // 2. fairness with all requesting
        do_reset();
        clear_logs();
        hold(8'hFF, 32'h9876_5432, 64);
        hold(8'h00, 32'h9876_5432, 4);
        check_eq("s2_tenures", ten_len.size() >= 9, 1);
        if (ten_len.size() >= 9 && own_log.size() >= 9) begin
            for (int i = 0; i < 9; i++) begin
                check_eq($sformatf("s2_owner%0d", i), own_log[i], i % N_REQ);
                check_eq($sformatf("s2_len%0d", i), ten_len[i], MAX_BEATS);
            end
        end

        // 3. no contention: tenure is not cut
        do_reset();
        clear_logs();
        hold(8'h20, 32'(3) << 20, 11);
        hold(8'h00, 32'(3) << 20, 4);
        check_eq("s3_tenures", ten_len.size(), 1);
        if (ten_len.size() >= 1) check_eq("s3_beats", ten_len[0], 10);

        // 4. illegal code 0
        clear_logs();
        hold(8'h02, 32'h0, 4);
        hold(8'h00, 32'h0, 4);
        check_eq("s4_err_pulses", n_errsel, 1);
        check_eq("s4_tenures", ten_len.size(), 1);
        if (ten_len.size() >= 1) check_eq("s4_beats", ten_len[0], 3);

        // 5. sel change during XFER is ignored
        clear_logs();
        hold(8'h10, 32'(7) << 16, 3);
        hold(8'h10, 32'(9) << 16, 4);
        hold(8'h00, 32'(9) << 16, 4);
        check_eq("s5_sel_changed", sel_bad, 0);

        // 6. asynchronous reset mid-XFER
        do_reset();
        clear_logs();
        hold(8'h08, 32'(5) << 12, 3);
        #2 rst = 1'b1;
        #1;
        check_eq("s6_grant_async", grant, 0);
        check_eq("s6_bus_en_async", bus_en, 0);
        check_eq("s6_vld_async", data_vld, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        clear_logs();
        hold(8'h09, 32'h0000_6004, 6);
        check_eq("s6_first_owner_seen", own_log.size() >= 1, 1);
        if (own_log.size() >= 1) check_eq("s6_first_owner", own_log[0], 0);

        // randomized traffic
        rnd_req = '0;
        rnd_sel = '0;
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < N_REQ; b++) begin
                if ($urandom_range(0, 5) == 0) rnd_req[b] = ~rnd_req[b];
                if ($urandom_range(0, 3) == 0) rnd_sel[b*SEL_W +: SEL_W] = SEL_W'($urandom_range(0, 15));
            end
            step(rnd_req, rnd_sel);
        end
        hold(8'h00, rnd_sel, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
